// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit position per clock over a start/busy/done handshake.
// Supports logical/arithmetic shifts, rotates, pass-through and clear.
module seq_shifter #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] amt,
  input  logic [2:0]         mode,
  output logic [WIDTH-1:0]   result,
  output logic               cout,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] MODE_SLL  = 3'b000;
  localparam logic [2:0] MODE_PASS = 3'b001;
  localparam logic [2:0] MODE_SRL  = 3'b010;
  localparam logic [2:0] MODE_SRA  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ROR  = 3'b110;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   work, work_d;
  logic [2:0]         mode_q, mode_d;
  logic [SHAMT_W-1:0] cnt, cnt_d;
  logic               last, last_d;
  logic [WIDTH-1:0]   result_d;
  logic               cout_d;
  logic               busy_d;
  logic               done_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      mode_q <= '0;
      cnt    <= '0;
      last   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      work   <= work_d;
      mode_q <= mode_d;
      cnt    <= cnt_d;
      last   <= last_d;
      result <= result_d;
      cout   <= cout_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d  = state;
    work_d   = work;
    mode_d   = mode_q;
    cnt_d    = cnt;
    last_d   = last;
    result_d = result;
    cout_d   = cout;
    done_d   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          last_d  = 1'b0;
          state_d = SHIFT;
          case (mode)
            MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR: begin
              work_d = din;
              cnt_d  = amt;
            end
            MODE_PASS: begin
              work_d = din;
              cnt_d  = '0;
            end
            default: begin
              work_d = '0;
              cnt_d  = '0;
            end
          endcase
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          cnt_d = cnt - SHAMT_W'(1);
          // last captures the bit leaving the word (or wrapping, for rotates)
          case (mode_q)
            MODE_SLL: begin
              work_d = {work[WIDTH-2:0], 1'b0};
              last_d = work[WIDTH-1];
            end
            MODE_SRL: begin
              work_d = {1'b0, work[WIDTH-1:1]};
              last_d = work[0];
            end
            MODE_SRA: begin
              work_d = {work[WIDTH-1], work[WIDTH-1:1]};
              last_d = work[0];
            end
            MODE_ROL: begin
              work_d = {work[WIDTH-2:0], work[WIDTH-1]};
              last_d = work[WIDTH-1];
            end
            MODE_ROR: begin
              work_d = {work[0], work[WIDTH-1:1]};
              last_d = work[0];
            end
            default: begin
              work_d = work;
              last_d = last;
            end
          endcase
        end else begin
          result_d = work;
          cout_d   = last;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
  end

endmodule
